// File: rtl/spi_mem_arbiter.sv
// Shares one SPI RAM master between the instruction-fetch port (F) and the data port (D).
// Arbitrates, latches the winning request, issues it and routes completion/timeout back to the winner.
module spi_mem_arbiter #(
    parameter int ARB_ROUND_ROBIN = 1,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk_core_i,
    input  logic        rst_n_i,
    input  logic        f_req_i,
    input  logic [15:0] f_addr_i,
    output logic        f_done_o,
    output logic [15:0] f_rdata_o,
    output logic        f_err_o,
    input  logic        d_req_i,
    input  logic [15:0] d_addr_i,
    input  logic [7:0]  d_wdata_i,
    input  logic        d_rnw_i,
    output logic        d_done_o,
    output logic [7:0]  d_rdata_o,
    output logic        d_err_o,
    output logic        m_start_o,
    output logic [15:0] m_addr_o,
    output logic [7:0]  m_wdata_o,
    output logic        m_rnw_o,
    output logic [1:0]  m_nbytes_o,
    input  logic [7:0]  m_rdata1_i,
    input  logic [7:0]  m_rdata2_i,
    input  logic        m_done_i,
    input  logic        m_busy_i
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic RR_EN = (ARB_ROUND_ROBIN != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // win_d: 1 = D owns the current transaction; ptr: 1 = D preferred on a tie
    logic             win_d_q, win_d_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        f_done_q, f_done_d;
    logic [15:0] f_rdata_q, f_rdata_d;
    logic        f_err_q, f_err_d;
    logic        d_done_q, d_done_d;
    logic [7:0]  d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;
    logic        m_start_q, m_start_d;
    logic [15:0] m_addr_q, m_addr_d;
    logic [7:0]  m_wdata_q, m_wdata_d;
    logic        m_rnw_q, m_rnw_d;
    logic [1:0]  m_nbytes_q, m_nbytes_d;

    logic grant_d_s;
    logic start_ok_s;
    logic timeout_s;

    assign start_ok_s = (f_req_i | d_req_i) & ~m_busy_i;
    assign timeout_s  = TO_EN & (cnt_q == CNT_LAST);

    // Winner selection for the IDLE cycle: a lone requester always wins, ties go by mode
    always_comb begin
        if (d_req_i && !f_req_i) begin
            grant_d_s = 1'b1;
        end else if (f_req_i && !d_req_i) begin
            grant_d_s = 1'b0;
        end else if (RR_EN) begin
            grant_d_s = ptr_q;
        end else begin
            grant_d_s = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_core_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            win_d_q    <= 1'b0;
            ptr_q      <= 1'b1;
            cnt_q      <= '0;
            f_done_q   <= 1'b0;
            f_rdata_q  <= 16'h0000;
            f_err_q    <= 1'b0;
            d_done_q   <= 1'b0;
            d_rdata_q  <= 8'h00;
            d_err_q    <= 1'b0;
            m_start_q  <= 1'b0;
            m_addr_q   <= 16'h0000;
            m_wdata_q  <= 8'h00;
            m_rnw_q    <= 1'b0;
            m_nbytes_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            win_d_q    <= win_d_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            f_done_q   <= f_done_d;
            f_rdata_q  <= f_rdata_d;
            f_err_q    <= f_err_d;
            d_done_q   <= d_done_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
            m_start_q  <= m_start_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_rnw_q    <= m_rnw_d;
            m_nbytes_q <= m_nbytes_d;
        end
    end

    // Next-state logic; m_done_i only matters in WAIT, so a late pulse elsewhere is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (m_done_i || timeout_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values, computed one cycle ahead so every port is a flop
    always_comb begin
        m_start_d  = 1'b0;
        f_done_d   = 1'b0;
        f_err_d    = 1'b0;
        d_done_d   = 1'b0;
        d_err_d    = 1'b0;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_rnw_d    = m_rnw_q;
        m_nbytes_d = m_nbytes_q;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
        win_d_d    = win_d_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    m_start_d = 1'b1;
                    win_d_d   = grant_d_s;
                    if (grant_d_s) begin
                        m_addr_d   = d_addr_i;
                        m_wdata_d  = d_wdata_i;
                        m_rnw_d    = d_rnw_i;
                        m_nbytes_d = 2'b01;
                    end else begin
                        m_addr_d   = f_addr_i;
                        m_wdata_d  = 8'h00;
                        m_rnw_d    = 1'b1;
                        m_nbytes_d = 2'b10;
                    end
                end else begin
                    m_start_d = 1'b0;
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion beats a coinciding timeout, so the error is only raised without m_done_i
                if (m_done_i || timeout_s) begin
                    f_done_d = ~win_d_q;
                    d_done_d = win_d_q;
                    f_err_d  = ~win_d_q & ~m_done_i;
                    d_err_d  = win_d_q & ~m_done_i;
                end else begin
                    f_done_d = 1'b0;
                    d_done_d = 1'b0;
                end
                if (m_done_i) begin
                    if (!win_d_q) begin
                        f_rdata_d = {m_rdata1_i, m_rdata2_i};
                    end else if (m_rnw_q) begin
                        d_rdata_d = m_rdata1_i;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    f_rdata_d = f_rdata_q;
                end
            end
            ST_RESP: begin
                if (RR_EN) begin
                    ptr_d = ~win_d_q;
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign f_done_o   = f_done_q;
    assign f_rdata_o  = f_rdata_q;
    assign f_err_o    = f_err_q;
    assign d_done_o   = d_done_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_err_o    = d_err_q;
    assign m_start_o  = m_start_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign m_rnw_o    = m_rnw_q;
    assign m_nbytes_o = m_nbytes_q;

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares one SPI RAM master between two requesters: the instruction-fetch port (F) and the load/store data port (D).
- The block arbitrates between them, latches the winner's request and drives the master's start/address/data/command inputs.
- It then waits for the master's completion pulse and returns read data plus a done/error pulse to the winning port.
- It sits between the CPU core's fetch/LSU units and the SPI master.

Parameters:
ARB_ROUND_ROBIN, 1, 1 = round-robin between F and D; 0 = fixed priority with D always winning over F
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort; 0 disables the timeout

Ports:
clk_core_i  in  1  core clock, all logic on rising edge
rst_n_i  in  1  synchronous active-low reset
f_req_i  in  1  fetch request, held with f_addr_i stable until f_done_o
f_addr_i  in  16  fetch address (always a 2-byte read)
f_done_o  out  1  one-cycle completion pulse for F
f_rdata_o  out  16  {byte@addr, byte@addr+1}
f_err_o  out  1  with f_done_o: transaction timed out
d_req_i  in  1  data request, held with fields stable until d_done_o
d_addr_i  in  16  data address
d_wdata_i  in  8  write byte
d_rnw_i  in  1  1 = read, 0 = write (always 1 byte)
d_done_o  out  1  one-cycle completion pulse for D
d_rdata_o  out  8  read byte
d_err_o  out  1  with d_done_o: timeout
m_start_o  out  1  one-cycle start pulse to SPI master
m_addr_o  out  16  master address
m_wdata_o  out  8  master write data
m_rnw_o  out  1  master read_not_write
m_nbytes_o  out  2  2'b10 for F, 2'b01 for D
m_rdata1_i  in  8  master read byte 1
m_rdata2_i  in  8  master read byte 2
m_done_i  in  1  master transaction_done pulse
m_busy_i  in  1  master busy

Behaviour:
- All outputs are registered.
- Reset (rst_n_i low at a clock edge) forces every output to 0, state to IDLE, timeout counter to 0 and the RR pointer to "D preferred".
- Reset applies in any state, including mid-WAIT. Any later m_done_i from the abandoned transfer is ignored, because m_done_i is honoured only in WAIT.
- IDLE state:
  - Leaves only when (f_req_i | d_req_i) and !m_busy_i.
  - Winner selection:
    - Only one port requesting: that port wins.
    - Both requesting, fixed mode: D wins.
    - Both requesting, RR mode: the pointer's port wins.
  - On leaving, latch winner id, m_addr_o, m_wdata_o, m_rnw_o and m_nbytes_o, then go to ISSUE.
  - F requests drive m_rnw_o = 1, m_nbytes_o = 2'b10 and m_wdata_o = 0.
  - D requests drive m_nbytes_o = 2'b01.
- ISSUE state: m_start_o = 1 for exactly this one cycle; clear the timeout counter; go to WAIT.
- m_addr_o, m_wdata_o, m_rnw_o and m_nbytes_o hold stable from ISSUE through RESP.
- WAIT state:
  - The counter increments each cycle.
  - If m_done_i is high: capture the master's read bytes, clear the error flag, go to RESP.
    - F: f_rdata_o <= {m_rdata1_i, m_rdata2_i}.
    - D with read: d_rdata_o <= m_rdata1_i.
    - D with write: d_rdata_o unchanged.
  - Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: set the error flag, leave rdata unchanged, go to RESP.
  - If m_done_i and the timeout coincide, m_done_i wins (no error).
- RESP state:
  - The winner's x_done_o = 1 for exactly this one cycle; x_err_o = error flag in the same cycle, 0 otherwise.
  - In RR mode, set the pointer to the other port.
  - Go to IDLE.
- Latency:
  - Request seen in IDLE to m_start_o: 1 cycle.
  - m_done_i to x_done_o: 1 cycle.
  - Earliest next m_start_o: 2 cycles after RESP.
- Handshake rules:
  - A requester drops x_req_i on the edge where it samples x_done_o.
  - A req still high in the following IDLE is a new request; back-to-back service is legal.
  - A requester must not drop req before done; if it does, the result is undefined and need not be handled.
- After a timeout, the next issue is deferred by the !m_busy_i gate until the master finishes. The late m_done_i arrives outside WAIT and is ignored.
- f_rdata_o and d_rdata_o hold their last value between completions.

Test Plan:
- Reset, then idle with both req low for 20 cycles -> all outputs 0, no m_start_o.
- Fetch: f_req_i = 1, f_addr_i = 0x1234, master model returns 0xAB/0xCD -> m_addr_o = 0x1234, m_rnw_o = 1, m_nbytes_o = 2'b10 and a single-cycle m_start_o. Then f_done_o one cycle after m_done_i, f_rdata_o = 0xABCD, f_err_o = 0, d_done_o stays 0.
- Data write: d_addr_i = 0x00FF, d_wdata_i = 0x5A, d_rnw_i = 0 -> m_rnw_o = 0, m_nbytes_o = 2'b01, m_wdata_o = 0x5A, one d_done_o pulse, d_rdata_o unchanged. Then data read returning 0x3C -> d_rdata_o = 0x3C.
- RR mode with both req held for 4 transactions -> grant order D, F, D, F. With ARB_ROUND_ROBIN = 0 -> D, D, D, and F is served only after d_req_i drops.
- TIMEOUT_CYCLES = 8 with the model holding m_busy_i high and never pulsing done -> d_done_o and d_err_o high 8 cycles after entering WAIT. With d_req_i still high, no new m_start_o until m_busy_i falls. A late m_done_i pulse during IDLE is ignored.
- Reset asserted mid-WAIT, then m_done_i pulses -> outputs 0, no x_done_o. m_busy_i high in IDLE with f_req_i = 1 -> no m_start_o until m_busy_i = 0.
